// File: rtl/seg7_capture.sv
// seg7_capture: samples two asynchronous 7-segment digits, waits until the
// pattern has been stable for STABLE_CYCLES cycles, decodes it to a byte and
// hands it to a consumer with a valid/ack handshake, overrun and error stats.
module seg7_capture #(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [6:0] seg_lo,
  input  logic [6:0] seg_hi,
  input  logic       clr,
  input  logic       data_ack,
  output logic [7:0] value,
  output logic       data_valid,
  output logic       overrun,
  output logic       bad_pattern,
  output logic [7:0] err_count
);

  typedef enum logic {LOCKED = 1'b0, SETTLE = 1'b1} state_t;

  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  // {valid, nibble} for one digit; GFEDCBA bit order, active-high segments
  function automatic logic [4:0] dec7(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'b0111111: r = 5'h10;
      7'b0000110: r = 5'h11;
      7'b1011011: r = 5'h12;
      7'b1001111: r = 5'h13;
      7'b1100110: r = 5'h14;
      7'b1101101: r = 5'h15;
      7'b1111101: r = 5'h16;
      7'b0000111: r = 5'h17;
      7'b1111111: r = 5'h18;
      7'b1100111: r = 5'h19;
      7'b1110111: r = 5'h1A;
      7'b1111100: r = 5'h1B;
      7'b0111001: r = 5'h1C;
      7'b1011110: r = 5'h1D;
      7'b1111001: r = 5'h1E;
      7'b1110001: r = 5'h1F;
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  logic [13:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [13:0] cand_q, cand_d;
  logic [7:0]  cnt_q, cnt_d;
  state_t      state_q, state_d;
  logic [7:0]  value_q, value_d;
  logic [7:0]  last_cap_q, last_cap_d;
  logic        have_cap_q, have_cap_d;
  logic        data_valid_q, data_valid_d;
  logic        overrun_q, overrun_d;
  logic        bad_pattern_q, bad_pattern_d;
  logic [7:0]  err_count_q, err_count_d;

  logic        decode_now;
  logic [4:0]  dec_hi, dec_lo;
  logic        pat_ok;
  logic [7:0]  dec_byte;
  logic        capture;

  // Two-stage synchronizer on the raw segment lines
  always_comb begin
    sync1_d = {seg_hi, seg_lo};
    sync2_d = sync1_q;
  end

  // Stability filter: any change restarts the count; a full run decodes once
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    decode_now = 1'b0;
    if (sync2_q != cand_q) begin
      cand_d  = sync2_q;
      cnt_d   = 8'd0;
      state_d = SETTLE;
    end else if (state_q == SETTLE) begin
      if (cnt_q == CNT_LAST) begin
        decode_now = 1'b1;
        state_d    = LOCKED;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // Decode of the settled candidate
  always_comb begin
    dec_hi   = dec7(cand_q[13:7]);
    dec_lo   = dec7(cand_q[6:0]);
    pat_ok   = dec_hi[4] & dec_lo[4];
    dec_byte = {dec_hi[3:0], dec_lo[3:0]};
    capture  = decode_now & pat_ok & (~have_cap_q | (dec_byte != last_cap_q));
  end

  // Output/handshake state: clr beats decode events, which beat data_ack
  always_comb begin
    value_d       = value_q;
    last_cap_d    = last_cap_q;
    have_cap_d    = have_cap_q;
    data_valid_d  = data_valid_q;
    overrun_d     = overrun_q;
    bad_pattern_d = 1'b0;
    err_count_d   = err_count_q;
    if (clr) begin
      value_d      = 8'd0;
      last_cap_d   = 8'd0;
      have_cap_d   = 1'b0;
      data_valid_d = 1'b0;
      overrun_d    = 1'b0;
      err_count_d  = 8'd0;
    end else begin
      if (decode_now && !pat_ok) begin
        bad_pattern_d = 1'b1;
        if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
      end
      if (capture) begin
        value_d      = dec_byte;
        last_cap_d   = dec_byte;
        have_cap_d   = 1'b1;
        data_valid_d = 1'b1;
        // data acked on the same edge is not lost, so no overrun then
        if (data_valid_q && !data_ack) overrun_d = 1'b1;
      end else if (data_ack && data_valid_q) begin
        data_valid_d = 1'b0;
      end
    end
  end

  // State registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      cand_q        <= '0;
      cnt_q         <= '0;
      state_q       <= LOCKED;
      value_q       <= '0;
      last_cap_q    <= '0;
      have_cap_q    <= 1'b0;
      data_valid_q  <= 1'b0;
      overrun_q     <= 1'b0;
      bad_pattern_q <= 1'b0;
      err_count_q   <= '0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      value_q       <= value_d;
      last_cap_q    <= last_cap_d;
      have_cap_q    <= have_cap_d;
      data_valid_q  <= data_valid_d;
      overrun_q     <= overrun_d;
      bad_pattern_q <= bad_pattern_d;
      err_count_q   <= err_count_d;
    end
  end

  assign value       = value_q;
  assign data_valid  = data_valid_q;
  assign overrun     = overrun_q;
  assign bad_pattern = bad_pattern_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: scoreboard bench; expected capture/bad events are queued as
// stimulus is driven and popped by a monitor as the DUT emits them.
module tb_seg7_capture;

  localparam logic [6:0] S0 = 7'b0111111;
  localparam logic [6:0] S1 = 7'b0000110;
  localparam logic [6:0] S2 = 7'b1011011;
  localparam logic [6:0] S8 = 7'b1111111;
  localparam logic [6:0] SE = 7'b1111001;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [6:0] seg_lo, seg_hi;
  logic       clr, data_ack;
  logic [7:0] value, err_count;
  logic       data_valid, overrun, bad_pattern;

  typedef struct {
    bit         is_bad;
    logic [7:0] val;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  seg7_capture #(.STABLE_CYCLES(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .seg_lo(seg_lo), .seg_hi(seg_hi), .clr(clr),
    .data_ack(data_ack), .value(value), .data_valid(data_valid),
    .overrun(overrun), .bad_pattern(bad_pattern), .err_count(err_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic push_ev(input bit is_bad, input logic [7:0] v);
    ev_t e;
    e.is_bad = is_bad;
    e.val    = v;
    exp_q.push_back(e);
  endtask

  task automatic pop_ev(input bit is_bad, input logic [7:0] v);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk(is_bad ? "unexpected_bad" : "unexpected_cap", exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      chk("ev_kind", {31'd0, is_bad}, {31'd0, e.is_bad});
      if (!is_bad) chk("cap_value", {24'd0, v}, {24'd0, e.val});
    end
  endtask

  // Monitor: a capture is data_valid rising or value changing while valid
  logic [7:0] prev_v  = 8'd0;
  logic       prev_dv = 1'b0;
  always @(negedge CLK) begin
    if (bad_pattern === 1'b1) pop_ev(1'b1, 8'd0);
    if (data_valid === 1'b1 && (value !== prev_v || prev_dv !== 1'b1)) pop_ev(1'b0, value);
    prev_v  = value;
    prev_dv = data_valid;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic ack_pulse();
    @(negedge CLK);
    data_ack = 1'b1;
    @(negedge CLK);
    data_ack = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; seg_lo = 7'd0; seg_hi = 7'd0; clr = 1'b0; data_ack = 1'b0;
    cyc(3);
    chk("rst_value", value, 0);
    chk("rst_dv", data_valid, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_bad", bad_pattern, 0);
    chk("rst_err", err_count, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    cyc(30);  // blank inputs from reset: nothing must happen
    chk("blank_err", err_count, 0);

    // 0x1E with latency check: edge 18 not yet, edge 19 captured
    @(negedge CLK);
    seg_hi = S1; seg_lo = SE;
    push_ev(1'b0, 8'h1E);
    cyc(18);
    chk("lat_e18_dv", data_valid, 0);
    cyc(1);
    chk("lat_e19_dv", data_valid, 1);
    chk("lat_e19_val", value, 8'h1E);
    cyc(11);
    chk("hold_dv", data_valid, 1);
    @(negedge CLK);
    data_ack = 1'b1;
    cyc(1);
    chk("ack_dv", data_valid, 0);
    chk("ack_val", value, 8'h1E);
    @(negedge CLK);
    data_ack = 1'b0;

    // short glitch to a valid digit must be filtered
    @(negedge CLK);
    seg_lo = S8;
    cyc(10);
    @(negedge CLK);
    seg_lo = SE;
    cyc(30);
    chk("glitch_dv", data_valid, 0);
    chk("glitch_val", value, 8'h1E);
    chk("glitch_err", err_count, 0);

    // blank digit -> one bad pulse; restoring same byte -> no event
    @(negedge CLK);
    seg_lo = 7'd0;
    push_ev(1'b1, 8'd0);
    cyc(20);
    chk("blank_err1", err_count, 1);
    chk("blank_val", value, 8'h1E);
    chk("blank_dv", data_valid, 0);
    @(negedge CLK);
    seg_lo = SE;
    cyc(30);
    chk("same_dv", data_valid, 0);

    // overrun: 0x18 (acked), 0x1E unacked, then 0x2E overwrites it
    @(negedge CLK);
    seg_lo = S8;
    push_ev(1'b0, 8'h18);
    cyc(25);
    chk("c18_val", value, 8'h18);
    ack_pulse();
    @(negedge CLK);
    seg_lo = SE;
    push_ev(1'b0, 8'h1E);
    cyc(25);
    chk("c1E_dv", data_valid, 1);
    chk("c1E_ovr", overrun, 0);
    @(negedge CLK);
    seg_hi = S2;
    push_ev(1'b0, 8'h2E);
    cyc(25);
    chk("c2E_val", value, 8'h2E);
    chk("c2E_dv", data_valid, 1);
    chk("c2E_ovr", overrun, 1);
    ack_pulse();
    cyc(1);
    chk("ovr_ack_dv", data_valid, 0);
    chk("ovr_sticky", overrun, 1);
    chk("pre_clr_err", err_count, 1);
    @(negedge CLK);
    clr = 1'b1;
    cyc(1);
    chk("clr_ovr", overrun, 0);
    chk("clr_err", err_count, 0);
    chk("clr_val", value, 0);
    @(negedge CLK);
    clr = 1'b0;

    // capture coincident with ack while previous data still unacked
    @(negedge CLK);
    seg_lo = S8;
    push_ev(1'b0, 8'h28);
    cyc(25);
    chk("c28_dv", data_valid, 1);
    @(negedge CLK);
    seg_lo = SE;
    push_ev(1'b0, 8'h2E);
    cyc(18);
    chk("co_pre_val", value, 8'h28);
    @(negedge CLK);
    data_ack = 1'b1;
    cyc(1);
    chk("co_val", value, 8'h2E);
    chk("co_dv", data_valid, 1);
    chk("co_ovr", overrun, 0);
    @(negedge CLK);
    data_ack = 1'b0;

    // error counter saturation, value/data_valid untouched by bad patterns
    for (int i = 0; i < 257; i++) begin
      @(negedge CLK);
      seg_lo = (i % 2 == 0) ? 7'b0000000 : 7'b0000001;
      push_ev(1'b1, 8'd0);
      cyc(22);
    end
    chk("sat_err", err_count, 8'hFF);
    chk("sat_val", value, 8'h2E);
    chk("sat_dv", data_valid, 1);

    // reset mid-SETTLE (cnt==8 after edge 11) abandons the decode
    @(negedge CLK);
    seg_hi = S1; seg_lo = S0;
    repeat (11) @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_val", value, 0);
    chk("arst_dv", data_valid, 0);
    chk("arst_err", err_count, 0);
    chk("arst_bad", bad_pattern, 0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    push_ev(1'b0, 8'h10);
    cyc(18);
    chk("rel_e18_dv", data_valid, 0);
    cyc(1);
    chk("rel_e19_dv", data_valid, 1);
    chk("rel_e19_val", value, 8'h10);
    chk("rel_ovr", overrun, 0);

    cyc(5);
    chk("pending_events", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
